// File: rtl/down_counter_161r.sv
// Presettable synchronous down counter with cascade enables, borrow lookahead (tc),
// registered underflow pulse (rc) and an auto-reload register loaded alongside q.
module down_counter_161r #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             cp,
  input  logic             mr,
  input  logic             pe,
  input  logic             cep,
  input  logic             cet,
  input  logic             arl,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             rc,
  output logic [WIDTH-1:0] rld
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rld;
  logic             r_rc;

  logic [WIDTH-1:0] w_q_d;
  logic [WIDTH-1:0] w_rld_d;
  logic             w_rc_d;
  logic             w_zero;
  logic             w_count;

  assign w_zero  = (r_q == '0);
  assign w_count = pe & cep & cet;

  always_comb begin
    w_q_d   = r_q;
    w_rld_d = r_rld;
    w_rc_d  = 1'b0;
    if (!pe) begin
      w_q_d   = d;
      w_rld_d = d;
    end else if (w_count) begin
      if (w_zero) begin
        // Underflow: either reload or wrap to all-ones.
        w_q_d  = arl ? r_rld : '1;
        w_rc_d = 1'b1;
      end else begin
        w_q_d = r_q - 1'b1;
      end
    end
  end

  always_ff @(posedge cp or posedge mr) begin
    if (mr) begin
      r_q   <= '0;
      r_rld <= '0;
      r_rc  <= 1'b0;
    end else begin
      r_q   <= w_q_d;
      r_rld <= w_rld_d;
      r_rc  <= w_rc_d;
    end
  end

  assign q   = r_q;
  assign rld = r_rld;
  assign rc  = r_rc;
  assign tc  = cet & w_zero;

endmodule

// File: tb/tb_down_counter_161r.sv
// Bench for down_counter_161r: vector table, reset/combinational corners, randomized
// run against an arithmetic reference model, and a two-stage cascade.
module tb_down_counter_161r;

  logic       cp = 1'b0;
  logic       mr;
  logic       pe, cep, cet, arl;
  logic [3:0] d;
  logic [3:0] q, rld;
  logic       tc, rc;

  // Cascade pair
  logic       c_pe, c_cep, c_cet;
  logic [7:0] c_d;
  logic [3:0] lo_q, hi_q, lo_rld, hi_rld;
  logic       lo_tc, hi_tc, lo_rc, hi_rc;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       pe, cep, cet, arl;
    logic [3:0] d;
    logic [3:0] eq;
    logic       etc, erc;
    logic [3:0] erld;
  } vec_t;
  vec_t vecs[$];

  // Reference model state
  int m_q, m_rld, m_rc;

  always #5 cp = ~cp;

  down_counter_161r #(.WIDTH(4)) u_dut (
    .cp(cp), .mr(mr), .pe(pe), .cep(cep), .cet(cet), .arl(arl), .d(d),
    .q(q), .tc(tc), .rc(rc), .rld(rld)
  );

  down_counter_161r #(.WIDTH(4)) u_lo (
    .cp(cp), .mr(mr), .pe(c_pe), .cep(c_cep), .cet(c_cet), .arl(1'b0), .d(c_d[3:0]),
    .q(lo_q), .tc(lo_tc), .rc(lo_rc), .rld(lo_rld)
  );

  down_counter_161r #(.WIDTH(4)) u_hi (
    .cp(cp), .mr(mr), .pe(c_pe), .cep(c_cep), .cet(lo_tc), .arl(1'b0), .d(c_d[7:4]),
    .q(hi_q), .tc(hi_tc), .rc(hi_rc), .rld(hi_rld)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge cp);
    #1;
  endtask

  task automatic add(input logic p, input logic ce, input logic ct, input logic a,
                     input logic [3:0] dd, input logic [3:0] eq, input logic et,
                     input logic er, input logic [3:0] erl);
    vec_t v;
    v.pe = p; v.cep = ce; v.cet = ct; v.arl = a; v.d = dd;
    v.eq = eq; v.etc = et; v.erc = er; v.erld = erl;
    vecs.push_back(v);
  endtask

  // One rising edge of the spec's priority rules, in plain integer arithmetic.
  task automatic model_edge();
    if (!pe) begin
      m_q = int'(d); m_rld = int'(d); m_rc = 0;
    end else if (cep && cet) begin
      if (m_q == 0) begin
        m_q  = arl ? m_rld : 15;
        m_rc = 1;
      end else begin
        m_q  = m_q - 1;
        m_rc = 0;
      end
    end else begin
      m_rc = 0;
    end
  endtask

  initial begin
    mr = 1'b1; pe = 1'b1; cep = 1'b0; cet = 1'b0; arl = 1'b0; d = '0;
    c_pe = 1'b1; c_cep = 1'b0; c_cet = 1'b0; c_d = '0;
    #12;
    chk("reset_state", {q, rld, 3'b0, rc, 3'b0, tc}, 32'h0000_0000);
    mr = 1'b0;

    //   pe cep cet arl d   q   tc rc rld
    add(0, 0, 0, 0, 3, 3,  0, 0, 3);
    add(1, 1, 1, 0, 0, 2,  0, 0, 3);
    add(1, 1, 1, 0, 0, 1,  0, 0, 3);
    add(1, 1, 1, 0, 0, 0,  1, 0, 3);
    add(1, 1, 1, 0, 0, 15, 0, 1, 3);
    add(1, 1, 1, 0, 0, 14, 0, 0, 3);
    add(0, 1, 1, 0, 2, 2,  0, 0, 2);
    add(1, 1, 1, 1, 0, 1,  0, 0, 2);
    add(1, 1, 1, 1, 0, 0,  1, 0, 2);
    add(1, 1, 1, 1, 0, 2,  0, 1, 2);
    add(1, 1, 1, 1, 0, 1,  0, 0, 2);
    add(1, 1, 1, 1, 0, 0,  1, 0, 2);
    add(1, 1, 1, 1, 0, 2,  0, 1, 2);
    add(0, 0, 0, 0, 5, 5,  0, 0, 5);
    for (int i = 0; i < 4; i++) add(1, 0, 1, 0, 0, 5, 0, 0, 5);
    for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 0, 5, 0, 0, 5);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0);
    add(0, 1, 1, 0, 7, 7,  0, 0, 7);
    add(0, 0, 0, 1, 0, 0,  0, 0, 0);
    add(1, 1, 1, 1, 0, 0,  1, 1, 0);
    add(1, 1, 1, 1, 0, 0,  1, 1, 0);
    add(1, 0, 1, 1, 0, 0,  1, 0, 0);

    foreach (vecs[i]) begin
      pe = vecs[i].pe; cep = vecs[i].cep; cet = vecs[i].cet; arl = vecs[i].arl;
      d = vecs[i].d;
      tick();
      chk($sformatf("vec%0d {q,tc,rc,rld}", i), {22'b0, q, tc, rc, rld},
          {22'b0, vecs[i].eq, vecs[i].etc, vecs[i].erc, vecs[i].erld});
    end

    // tc is combinational on cet: no edge between the two checks.
    pe = 1'b0; d = 4'd0; cep = 1'b0; cet = 1'b0;
    tick();
    pe = 1'b1;
    #1;
    chk("tc_cet0", {31'b0, tc}, 32'd0);
    cet = 1'b1;
    #1;
    chk("tc_cet1_comb", {31'b0, tc}, 32'd1);

    // Asynchronous mid-cycle reset with q=9, rld=9; edges ignored while held.
    cet = 1'b0; pe = 1'b0; d = 4'd9;
    tick();
    chk("pre_reset_q9", {24'b0, q, rld}, {24'b0, 8'h99});
    #3 mr = 1'b1;
    #1;
    chk("async_reset", {23'b0, q, rld, rc}, 32'd0);
    pe = 1'b0; d = 4'd5;
    tick();
    chk("reset_holds", {23'b0, q, rld, rc}, 32'd0);
    #2 mr = 1'b0;
    pe = 1'b1; cep = 1'b1; cet = 1'b1; arl = 1'b0;
    tick();
    chk("after_release", {23'b0, q, rld, rc}, {23'b0, 4'd15, 4'd0, 1'b1});

    // Randomized run against the model.
    m_q = 15; m_rld = 0; m_rc = 1;
    for (int i = 0; i < 300; i++) begin
      pe  = ($urandom_range(0, 7) != 0);
      cep = ($urandom_range(0, 5) != 0);
      cet = ($urandom_range(0, 5) != 0);
      arl = $urandom_range(0, 1) != 0;
      d   = 4'($urandom_range(0, 15));
      model_edge();
      tick();
      chk($sformatf("rand%0d {q,tc,rc,rld}", i), {22'b0, q, tc, rc, rld},
          {22'b0, 4'(m_q), (cet && m_q == 0), 1'(m_rc), 4'(m_rld)});
    end

    // Two-stage cascade: 8'h10 counting down through 00 to FF.
    c_pe = 1'b0; c_d = 8'h10;
    tick();
    chk("casc_load", {24'b0, hi_q, lo_q}, 32'h10);
    c_pe = 1'b1; c_cep = 1'b1; c_cet = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk($sformatf("casc_step%0d", k), {24'b0, hi_q, lo_q}, 32'((16 - k + 256) % 256));
    end
    chk("casc_hi_rc", {31'b0, hi_rc}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/down_counter_161r.md
Name: down_counter_161r

Overview:
- Presettable synchronous binary down counter with cascade enables and a borrow lookahead output.
- It is the count-down counterpart of the team's 4-bit up counter, and it uses the same control set: parallel load, CEP/CET, and terminal count.
- It adds an auto-reload register, so the counter can act as a programmable divider/timer that feeds the up-counter chains in the sequential-circuit experiments.
- Cascades like the up counter: TC of one stage drives CET of the next.

Parameters:
- WIDTH, 4, counter width in bits (legal ≥ 2).

Ports:
- cp  input  1  clock; all state changes on rising edge.
- mr  input  1  asynchronous active-high reset (master reset).
- pe  input  1  synchronous parallel load, active-low.
- cep  input  1  count enable, parallel (local).
- cet  input  1  count enable, trickle (cascade); also gates tc.
- arl  input  1  auto-reload enable: on underflow, load the reload register instead of wrapping.
- d  input  WIDTH  parallel load data.
- q  output  WIDTH  counter value.
- tc  output  1  terminal count (borrow lookahead), combinational.
- rc  output  1  registered one-cycle underflow/reload pulse.
- rld  output  WIDTH  current reload register contents (debug/cascade readback).

Behaviour:
- Reset:
  - mr=1 forces q=0, rld=0, rc=0 immediately, independent of cp.
  - While mr=1, cp edges are ignored.
  - Release takes effect from the first rising cp after mr falls.
- Priority at each rising cp (mr=0), highest first:
  1. pe=0 (load): q<=d, rld<=d, rc<=0. cep/cet are ignored.
  2. pe=1, cep=1, cet=1, q≠0: q<=q-1, rc<=0.
  3. pe=1, cep=1, cet=1, q=0 (underflow):
     - If arl=1: q<=rld.
     - If arl=0: q<=all-ones (2^WIDTH-1, modulo wrap).
     - In both cases rc<=1.
  4. Otherwise: hold q, rc<=0.
- rld changes only on load or reset; it is never altered by counting.
- tc = cet & (q==0):
  - Purely combinational, with no dependence on cep or pe.
  - Asserts the cycle before underflow, so a downstream stage with cet=tc decrements on the same edge this stage underflows.
- rc:
  - High for exactly the one cycle following an underflow edge.
  - Consecutive underflows produce rc high on consecutive cycles; this happens when rld=0 with arl=1, where q stays 0 and rc stays 1 while enabled.
- Arithmetic: unsigned, WIDTH bits, no saturation. Decrement from 0 is handled only by rule 3.
- Load of d=0: q=0 next cycle, so tc=cet immediately after.
- arl sampled at the underflow edge only. Changing arl mid-count has no other effect.
- Reset asserted mid-count: q, rld, and rc clear asynchronously. The reload value is lost, and the next load must re-establish it.
- No internal enable pipelining: latency from cep/cet to the q change is one edge.
- Latency from pe to q is one edge.
- No X on any output after reset.

Test Plan:
- Reset:
  - Stimulus: mr=1 pulse mid-cycle, with q=9 and rld=9.
  - Response: q=0, rld=0, rc=0 before the next cp edge. Counting resumes on the first edge after mr=0.
- Load and count down, no reload:
  - Stimulus: pe=0 with d=3 for one edge, then cep=cet=1, arl=0.
  - Response: q=3,2,1,0,15,14. tc=1 only while q=0. rc=1 only in the cycle q=15.
- Auto-reload divider:
  - Stimulus: load d=2, then arl=1, cep=cet=1.
  - Response: q=2,1,0,2,1,0,… with period 3. rc pulses once per period, in the cycle q returns to 2.
- Enable gating:
  - Stimulus: q=5, with cep=0 for 4 edges, then cet=0 for 3 edges.
  - Response: q holds 5 throughout.
  - Stimulus: with q=0 and cet=0.
  - Response: tc=0. Setting cet=1 sets tc=1 immediately without waiting for an edge.
- Priority and simultaneous events:
  - Stimulus: q=0, cep=cet=1, pe=0, d=7 on the same edge.
  - Response: q=7, rc=0 (load wins).
  - Stimulus: load d=0 with arl=1, then enable.
  - Response: q stays 0 and rc stays 1 every enabled cycle.
- Cascade:
  - Stimulus: two instances, with tc of the low stage driving cet of the high stage. Load 8'h10, shared cep=1, low-stage cet=1.
  - Response: sequence 10,0F,0E,…,00,FF. The high stage decrements only on the edge where the low stage underflows.
